// File: rtl/bit_serializer_if.sv
// Handshake and serial-stream bundle for bit_serializer.
// The master side presents parallel words and the shift strobe; the slave
// side (the serializer) returns readiness, the serial bit and its status.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             shift_en;
    logic             dout;
    logic             dout_valid;
    logic             word_done;
    logic [IDX_W-1:0] bit_idx;

    modport master (
        output din, din_valid, shift_en,
        input  din_ready, dout, dout_valid, word_done, bit_idx
    );

    modport slave (
        input  din, din_valid, shift_en,
        output din_ready, dout, dout_valid, word_done, bit_idx
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding a serial sequence detector.
// Words are accepted with a valid/ready handshake and shifted out one bit per
// consume (dout_valid && shift_en). The last consume of a word can reload the
// next word in the same cycle, so back-to-back words stream without a bubble.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int IDLE_BIT  = 0
) (
    input  logic           clk,
    input  logic           reset,
    bit_serializer_if.slave bus
);
    localparam int               IDX_W  = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(WIDTH - 1);
    localparam logic             IDLE_B = (IDLE_BIT != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] idx;

    logic             head;
    logic             last;
    logic             in_shift;
    logic             consume;
    logic             ready;
    logic             accept;
    logic [WIDTH-1:0] sreg_adv;

    // Handshake, head-bit selection and output decode; reset masks every status output.
    always_comb begin
        head     = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
        sreg_adv = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg[WIDTH-1:1]};
        last     = (idx == LAST);
        in_shift = !reset && (state == SHIFT);
        consume  = in_shift && bus.shift_en;
        ready    = !reset && ((state == IDLE) || (last && bus.shift_en));
        accept   = bus.din_valid && ready;

        bus.din_ready  = ready;
        bus.dout_valid = in_shift;
        bus.dout       = in_shift ? head : IDLE_B;
        bus.word_done  = consume && last;
        bus.bit_idx    = in_shift ? idx : '0;
    end

    // Two-state FSM owning the shift register and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg  <= bus.din;
                        idx   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (consume) begin
                        if (last) begin
                            idx <= '0;
                            if (accept) begin
                                sreg <= bus.din;
                            end else begin
                                sreg  <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            sreg <= sreg_adv;
                            idx  <= idx + IDX_W'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule
